ad9252_test_ctrl: RTL
=====================

Name: ad9252_test_ctrl

Overview:
- SPI write-only master that configures the AD9252 ADC for the LVDS data-alignment sequence.
- On start, it programs user test pattern 1 (PATTERN) and selects user-pattern test mode, then raises ad_test_done.
- ad_test_done is the input the IDELAY alignment FSM waits on. That FSM raises dat_aligned when done.
- On dat_aligned, this block restores normal ADC output mode and flags normal_mode.

Parameters:
- CLK_DIV, 4, clk_ref cycles per SCLK half-period (>=1).
- GAP_CYC, 8, clk_ref cycles CSB held high between frames (>=1).
- PATTERN, 14'h2867, 14-bit user test pattern written to the ADC.

Ports:
- clk_ref  in  1  reference clock; all logic on posedge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins the test-mode sequence.
- dat_aligned  in  1  level from the alignment FSM; data lanes aligned.
- csb  out  1  ADC SPI chip select, active-low.
- sclk  out  1  ADC SPI clock.
- sdio  out  1  ADC SPI data, write only, never tristated.
- busy  out  1  high while a frame or gap is in progress.
- ad_test_done  out  1  test pattern active on ADC outputs.
- normal_mode  out  1  ADC restored to normal output.

Behaviour:
- Reset values, applied on any cycle with reset high, including mid-frame:
  - csb=1, sclk=0, sdio=0, busy=0, ad_test_done=0, normal_mode=0.
  - FSM returns to IDLE; no partial-frame completion afterwards.
- Frame format: 24 bits, MSB first = {1'b0 (write), 2'b00 (one byte), addr[12:0], data[7:0]}.
- Word ROM, index 0..5:
  - 0: 0x001967 (reg 0x19 = PATTERN[7:0])
  - 1: 0x001A28 (reg 0x1A = {2'b00, PATTERN[13:8]})
  - 2: 0x000D08 (test_io = user pattern)
  - 3: 0x00FF01 (transfer)
  - 4: 0x000D00 (test_io = off)
  - 5: 0x00FF01 (transfer)
- FSM states: IDLE, LOAD, SHIFT, GAP, TEST_WAIT, DONE.
  - IDLE: on start, index=0 -> LOAD. normal_mode and ad_test_done are cleared on the start cycle.
  - LOAD: one cycle. Shift register <= ROM[index], bit count=24, then csb drops (registered), sdio=bit23, sclk=0 -> SHIFT.
  - SHIFT, per bit:
    - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - sdio changes only on the cycle sclk goes low, so the ADC samples on the rising edge.
    - After the 24th high phase: sclk=0, csb=1 -> GAP.
    - csb is low for exactly 48*CLK_DIV cycles per frame.
    - Exactly 24 sclk rising edges per frame.
  - GAP: GAP_CYC cycles with csb high, then:
    - index 0..2 -> index+1, LOAD.
    - index 3 -> TEST_WAIT, ad_test_done=1.
    - index 4 -> index 5, LOAD.
    - index 5 -> DONE.
  - TEST_WAIT: busy=0, ad_test_done held 1. dat_aligned is level-sensed. When high: ad_test_done=0, index=4 -> LOAD next cycle.
  - DONE: normal_mode=1, busy=0. start re-runs from index 0, clearing normal_mode.
- busy=1 in LOAD/SHIFT/GAP, else 0.
- start outside IDLE/DONE is ignored. start coincident with reset: reset wins.
- dat_aligned already high on TEST_WAIT entry: restore begins on the next cycle.
- dat_aligned high outside TEST_WAIT: ignored.
- Counter widths sized to CLK_DIV and GAP_CYC. No wrap occurs within a state.

Test Plan:
- CLK_DIV=2, GAP_CYC=4, pulse start, dat_aligned=0:
  - Four frames decoded by an SPI monitor on rising sclk: 0x001967, 0x001A28, 0x000D08, 0x00FF01.
  - Each frame: csb low 96 cycles, 24 rising edges, >=4 cycles csb high between frames.
  - ad_test_done rises after the 4th gap; busy=0 from then on.
- Continue: assert dat_aligned -> ad_test_done falls the next cycle.
  - Frames 0x000D00 and 0x00FF01 are sent.
  - normal_mode=1 after the final gap; csb stays 1.
- Hold dat_aligned=1 from time 0, pulse start -> first four frames unchanged; restore begins one cycle after TEST_WAIT is entered.
- Pulse start repeatedly while busy -> still exactly 4 frames before ad_test_done; no extra frames.
- Assert reset during bit 10 of frame 1 -> next cycle csb=1, sclk=0, sdio=0, busy=0. A following start resends from 0x001967.
- Pulse start in DONE -> normal_mode clears the same cycle; the full six-frame sequence repeats.

Source files
------------

// File: rtl/ad9252_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ad9252_test_ctrl
// Purpose  : Write-only SPI master that puts the AD9252 ADC into user test
//            pattern mode for LVDS data alignment, waits for the alignment
//            FSM, then restores normal ADC output mode.
// Ports    : clk_ref      - reference clock, all logic on posedge
//            reset        - synchronous reset, active-high
//            start        - one-cycle pulse, begins the test-mode sequence
//            dat_aligned  - level from alignment FSM, data lanes aligned
//            csb          - ADC SPI chip select, active-low
//            sclk         - ADC SPI clock
//            sdio         - ADC SPI data (write only, always driven)
//            busy         - high while a frame or inter-frame gap runs
//            ad_test_done - test pattern active on ADC outputs
//            normal_mode  - ADC restored to normal output
// Revision : 1.0 - initial release
// ============================================================================
module ad9252_test_ctrl #(
    parameter int          CLK_DIV = 4,
    parameter int          GAP_CYC = 8,
    parameter logic [13:0] PATTERN = 14'h2867
) (
    input  logic clk_ref,
    input  logic reset,
    input  logic start,
    input  logic dat_aligned,
    output logic csb,
    output logic sclk,
    output logic sdio,
    output logic busy,
    output logic ad_test_done,
    output logic normal_mode
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_gap_w = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYC - 1);
    localparam logic [4:0]         c_bit_last = 5'd23;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_load      = 3'd1;
    localparam logic [2:0] c_st_shift     = 3'd2;
    localparam logic [2:0] c_st_gap       = 3'd3;
    localparam logic [2:0] c_st_test_wait = 3'd4;
    localparam logic [2:0] c_st_done      = 3'd5;

    // Frame = {write=0, one byte=00, addr[12:0], data[7:0]}
    function automatic logic [23:0] rom_word(input logic [2:0] idx);
        logic [23:0] w;
        case (idx)
            3'd0:    w = {3'b000, 13'h0019, PATTERN[7:0]};
            3'd1:    w = {3'b000, 13'h001A, 2'b00, PATTERN[13:8]};
            3'd2:    w = {3'b000, 13'h000D, 8'h08};
            3'd3:    w = {3'b000, 13'h00FF, 8'h01};
            3'd4:    w = {3'b000, 13'h000D, 8'h00};
            3'd5:    w = {3'b000, 13'h00FF, 8'h01};
            default: w = 24'h000000;
        endcase
        return w;
    endfunction

    logic [2:0]         r_state, w_state;
    logic [2:0]         r_idx, w_idx;
    logic [23:0]        r_shift, w_shift;
    logic [4:0]         r_bit, w_bit;
    logic [c_div_w-1:0] r_div, w_div;
    logic [c_gap_w-1:0] r_gap, w_gap;
    logic               r_csb, w_csb;
    logic               r_sclk, w_sclk;
    logic               r_test_done, w_test_done;
    logic               r_normal, w_normal;
    logic [23:0]        w_rom;

    always_ff @(posedge clk_ref) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_idx       <= 3'd0;
            r_shift     <= 24'h000000;
            r_bit       <= 5'd0;
            r_div       <= '0;
            r_gap       <= '0;
            r_csb       <= 1'b1;
            r_sclk      <= 1'b0;
            r_test_done <= 1'b0;
            r_normal    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_shift     <= w_shift;
            r_bit       <= w_bit;
            r_div       <= w_div;
            r_gap       <= w_gap;
            r_csb       <= w_csb;
            r_sclk      <= w_sclk;
            r_test_done <= w_test_done;
            r_normal    <= w_normal;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_shift     = r_shift;
        w_bit       = r_bit;
        w_div       = r_div;
        w_gap       = r_gap;
        w_csb       = r_csb;
        w_sclk      = r_sclk;
        w_test_done = r_test_done;
        w_normal    = r_normal;
        w_rom       = rom_word(r_idx);

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_idx       = 3'd0;
                    w_normal    = 1'b0;
                    w_test_done = 1'b0;
                    w_state     = c_st_load;
                end
            end

            c_st_load: begin
                // sdio is the MSB of the shift register, so bit 23 is on
                // the wire in the same cycle csb drops.
                w_shift = w_rom;
                w_bit   = 5'd0;
                w_div   = '0;
                w_sclk  = 1'b0;
                w_csb   = 1'b0;
                w_state = c_st_shift;
            end

            c_st_shift: begin
                if (r_div == c_div_last) begin
                    w_div = '0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        // End of a high phase: sclk falls and data advances
                        // together, keeping sdio stable around the rising edge.
                        w_sclk = 1'b0;
                        if (r_bit == c_bit_last) begin
                            w_csb   = 1'b1;
                            w_shift = 24'h000000;
                            w_gap   = '0;
                            w_state = c_st_gap;
                        end else begin
                            w_bit   = r_bit + 5'd1;
                            w_shift = {r_shift[22:0], 1'b0};
                        end
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end

            c_st_gap: begin
                if (r_gap == c_gap_last) begin
                    case (r_idx)
                        3'd3: begin
                            w_test_done = 1'b1;
                            w_state     = c_st_test_wait;
                        end
                        3'd5: begin
                            w_normal = 1'b1;
                            w_state  = c_st_done;
                        end
                        default: begin
                            w_idx   = r_idx + 3'd1;
                            w_state = c_st_load;
                        end
                    endcase
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end

            c_st_test_wait: begin
                if (dat_aligned) begin
                    w_test_done = 1'b0;
                    w_idx       = 3'd4;
                    w_state     = c_st_load;
                end
            end

            c_st_done: begin
                if (start) begin
                    w_idx    = 3'd0;
                    w_normal = 1'b0;
                    w_state  = c_st_load;
                end
            end

            default: begin
                w_state = c_st_idle;
            end
        endcase
    end

    assign csb          = r_csb;
    assign sclk         = r_sclk;
    assign sdio         = r_shift[23];
    assign busy         = (r_state == c_st_load) || (r_state == c_st_shift) ||
                          (r_state == c_st_gap);
    assign ad_test_done = r_test_done;
    assign normal_mode  = r_normal;

endmodule
`default_nettype wire
